divider_seq: RTL



---
 rtl/divider_seq.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
// Sequential radix-2 restoring integer divider. It resolves one quotient bit
// per enabled cycle and reports quotient, remainder and a divide-by-zero flag.
//
// Parameters
//   SIGNED : 1 = two's-complement operands/results (quotient truncates toward
//            zero, remainder takes the dividend's sign); 0 = unsigned
//   IA_W   : dividend / quotient width (>= IB_W)
//   IB_W   : divisor / remainder width (>= 2)
//
// Ports
//   i_clk    : clock
//   i_rstn   : asynchronous active-low reset
//   i_en_ff  : global clock enable; when low, every register holds
//   i_valid  : operands valid          o_ready : idle, operands accepted
//   i_a      : dividend                i_b     : divisor
//   o_valid  : result valid            i_ready : consumer takes the result
//   o_quot   : quotient                o_rem   : remainder
//   o_dbz    : divide-by-zero flag, qualified by o_valid
//
// Timing: the accepting edge counts as cycle 1. After it come IA_W CALC
// cycles and one FIX cycle, so o_valid rises on the IA_W+2-th enabled edge
// and a back-to-back operation occupies IA_W+3 cycles.
// -----------------------------------------------------------------------------
module divider_seq #(
    parameter bit SIGNED = 1'b0,
    parameter int IA_W   = 32,
    parameter int IB_W   = 16
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_en_ff,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [IA_W-1:0] i_a,
    input  logic [IB_W-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [IA_W-1:0] o_quot,
    output logic [IB_W-1:0] o_rem,
    output logic            o_dbz
);

    localparam int CW = $clog2(IA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]   cnt;
    // Dividend magnitude; quotient bits shift in at the LSB as dividend bits
    // leave at the MSB, so after IA_W steps this register holds the quotient.
    logic [IA_W-1:0] dvd;
    logic [IB_W-1:0] rem_r;
    logic [IB_W-1:0] dvs;
    logic [IB_W-1:0] a_low;   // original low dividend bits, returned on dbz
    logic            sign_a;
    logic            sign_b;
    logic            dbz;

    logic            accept;
    logic            consume;
    logic            last_step;

    logic            neg_a;
    logic            neg_b;
    logic [IA_W-1:0] abs_a;
    logic [IB_W-1:0] abs_b;

    logic [IB_W:0]   r_shift;
    logic [IB_W-1:0] r_diff;
    logic            qbit;

    logic [IA_W-1:0] quot_fix;
    logic [IB_W-1:0] rem_fix;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    assign accept    = i_en_ff && i_valid && (state == IDLE);
    assign consume   = i_en_ff && i_ready && (state == DONE);
    assign last_step = (cnt == CW'(IA_W - 1));

    // The magnitude of the most-negative value is its own bit pattern, which
    // plain two's-complement negation already produces.
    assign neg_a = SIGNED && i_a[IA_W-1];
    assign neg_b = SIGNED && i_b[IB_W-1];
    assign abs_a = neg_a ? -i_a : i_a;
    assign abs_b = neg_b ? -i_b : i_b;

    // One restoring step on the IB_W+1 bit partial remainder. When the
    // subtraction is taken the true difference is below the divisor, so
    // the low IB_W bits of the difference are exact.
    assign r_shift = {rem_r, dvd[IA_W-1]};
    assign qbit    = (r_shift >= {1'b0, dvs});
    assign r_diff  = r_shift[IB_W-1:0] - dvs;

    always_comb begin
        if (dbz) begin
            quot_fix = '1;
            rem_fix  = a_low;
        end else begin
            quot_fix = (sign_a ^ sign_b) ? -dvd : dvd;
            rem_fix  = sign_a ? -rem_r : rem_r;
        end
    end

    // NOTE: every signal assigned in always_comb receives a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (i_en_ff) begin
            case (state)
                IDLE:    if (i_valid) state_nxt = CALC;
                CALC:    if (last_step) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    if (i_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the datapath registers are reset as well, so an aborted operation
    // leaves no stale operands or partial results behind.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt    <= '0;
            dvd    <= '0;
            rem_r  <= '0;
            dvs    <= '0;
            a_low  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dbz    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            dvd    <= abs_a;
            rem_r  <= '0;
            dvs    <= abs_b;
            a_low  <= i_a[IB_W-1:0];
            sign_a <= neg_a;
            sign_b <= neg_b;
            dbz    <= (i_b == '0);
        end else if (i_en_ff && (state == CALC)) begin
            cnt   <= cnt + 1'b1;
            dvd   <= {dvd[IA_W-2:0], qbit};
            rem_r <= qbit ? r_diff : r_shift[IB_W-1:0];
        end
    end

    // Result registers only change in FIX, so they keep their values after
    // the handshake until the next operation completes.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_quot <= '0;
            o_rem  <= '0;
            o_dbz  <= 1'b0;
        end else if (i_en_ff && (state == FIX)) begin
            o_quot <= quot_fix;
            o_rem  <= rem_fix;
            o_dbz  <= dbz;
        end
    end

    // consume only feeds the FSM through i_ready; kept as a named term for
    // readability of the handshake condition.
    logic unused_ok;
    assign unused_ok = consume;

endmodule
